// File: rtl/nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Wide add/subtract sequencer built around one shared, external 4-bit
// combinational ripple-carry adder. An accepted request is processed one
// nibble per clock, least-significant nibble first. The carry is held in a
// register between nibbles, and the wide result is assembled in place.
//
// Parameters
//   WORDS    number of 4-bit nibbles per operand (operand width 4*WORDS),
//            legal range 1..16.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset (priority over start)
//   start     request; sampled only while ready = 1
//   sub       0: a + b + cin, 1: a - b (b inverted, carry-in forced to 1)
//   a, b      operands, sampled with start
//   cin       carry-in for add, sampled with start (ignored for sub)
//   ready     high while idle and able to accept a request
//   busy      high while an operation is running or completing
//   done      one-cycle completion pulse
//   result    wide sum/difference, held until the next accepted start
//   cout      final carry out (for sub: 1 = no borrow), held with result
//   add_a     nibble of A driven to the shared adder
//   add_b     nibble of B (possibly inverted) driven to the shared adder
//   add_cin   carry driven to the shared adder
//   add_sum   adder sum, combinational in the same cycle
//   add_cout  adder carry out, combinational in the same cycle
// ---------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sub,
    input  logic [4*WORDS-1:0] a,
    input  logic [4*WORDS-1:0] b,
    input  logic               cin,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [4*WORDS-1:0] result,
    output logic               cout,
    output logic [3:0]         add_a,
    output logic [3:0]         add_b,
    output logic               add_cin,
    input  logic [3:0]         add_sum,
    input  logic               add_cout
);

    localparam int W     = 4 * WORDS;
    // A single-nibble configuration still needs a one-bit index.
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;     // already inverted for subtraction
    logic             carry;     // carry into the current nibble
    logic [IDX_W-1:0] idx;       // nibble being processed
    logic [IDX_W+1:0] bit_base;  // bit offset of nibble idx (idx * 4)

    assign bit_base = {idx, 2'b00};

    // -----------------------------------------------------------------------
    // Adder drive: the shared adder only sees our operands while running, so
    // other users of the bus observe a quiet zero otherwise.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == S_RUN) begin
            add_a   = a_reg[bit_base +: 4];
            add_b   = b_reg[bit_base +: 4];
            add_cin = carry;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer: state, handshake outputs and datapath registers together.
    // ready/busy/done are registered alongside the state so they are glitch
    // free and change exactly on the state transitions.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: operand registers are reset along with the control state;
            // they are narrow registers, not a memory array, so the reset is
            // cheap and keeps the adder inputs deterministic.
            state  <= S_IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the pre-edge values of its inputs.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        // Subtraction is a + ~b + 1: invert b once here and
                        // force the initial carry; cin has no role.
                        b_reg  <= sub ? ~b : b;
                        carry  <= sub ? 1'b1 : cin;
                        idx    <= '0;
                        result <= '0;
                        state  <= S_RUN;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                    end
                end

                S_RUN: begin
                    result[bit_base +: 4] <= add_sum;
                    carry                 <= add_cout;
                    if (idx == LAST_IDX) begin
                        cout  <= add_cout;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
//
// Two instances of the sequencer (WORDS = 4 and WORDS = 1), each paired with
// its own behavioural 4-bit adder. Expected values come from whole-word
// arithmetic on the operands, not from a nibble-by-nibble replay.
// ---------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- WORDS = 4 instance ----------------
    logic        reset4 = 1'b1, start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [15:0] a4 = '0, b4 = '0;
    logic        ready4, busy4, done4, cout4;
    logic [15:0] result4;
    logic [3:0]  add_a4, add_b4, add_sum4;
    logic        add_cin4, add_cout4;

    assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'd0, add_cin4};

    nibble_serial_add_ctrl #(.WORDS(4)) dut4 (
        .clk(clk), .reset(reset4), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .cin(cin4), .ready(ready4), .busy(busy4), .done(done4), .result(result4),
        .cout(cout4), .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4)
    );

    // ---------------- WORDS = 1 instance ----------------
    logic        reset1 = 1'b1, start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
    logic [3:0]  a1 = '0, b1 = '0;
    logic        ready1, busy1, done1, cout1;
    logic [3:0]  result1;
    logic [3:0]  add_a1, add_b1, add_sum1;
    logic        add_cin1, add_cout1;

    assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'd0, add_cin1};

    nibble_serial_add_ctrl #(.WORDS(1)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .cin(cin1), .ready(ready1), .busy(busy1), .done(done1), .result(result1),
        .cout(cout1), .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move the inputs to values unrelated to the operation in flight.
    task automatic scramble4();
        a4   = 16'($urandom);
        b4   = 16'($urandom);
        cin4 = 1'($urandom);
        sub4 = 1'($urandom);
    endtask

    // One full WORDS = 4 operation. inject selects a cycle (0..3 = RUN
    // cycle, 4 = DONE cycle) in which a stray start pulse is driven; any
    // other value means no stray pulse.
    task automatic run_op4(input logic [15:0] av, input logic [15:0] bv,
                           input logic cv, input logic sv, input int inject);
        logic [63:0] aa, bb, beff, full, exp_res, m;
        logic        c0, exp_c;
        aa   = {48'd0, av};
        bb   = {48'd0, bv};
        beff = sv ? {48'd0, ~bv} : bb;
        c0   = sv ? 1'b1 : cv;
        if (sv) begin
            exp_res = (aa - bb) & 64'hFFFF;
            exp_c   = (aa >= bb);
        end else begin
            full    = aa + bb + {63'd0, cv};
            exp_res = full & 64'hFFFF;
            exp_c   = full[16];
        end

        @(negedge clk);
        a4 = av; b4 = bv; cin4 = cv; sub4 = sv; start4 = 1'b1;
        @(posedge clk); #1;
        check("accept_ready", ready4, 0);
        for (int i = 0; i < 4; i++) begin
            m = (64'd1 << (4 * i)) - 64'd1;
            check("run_busy", busy4, 1);
            check("run_done", done4, 0);
            check("run_ready", ready4, 0);
            check("run_partial", result4, exp_res & m);
            check("run_add_a", add_a4, (aa >> (4 * i)) & 64'hF);
            check("run_add_b", add_b4, (beff >> (4 * i)) & 64'hF);
            check("run_add_cin", add_cin4, ((aa & m) + (beff & m) + {63'd0, c0}) >> (4 * i));
            @(negedge clk);
            start4 = (inject == i);
            scramble4();
            @(posedge clk); #1;
        end
        check("done_pulse", done4, 1);
        check("done_busy", busy4, 1);
        check("done_result", result4, exp_res);
        check("done_cout", cout4, exp_c);
        check("done_add_a", add_a4, 0);
        @(negedge clk);
        start4 = (inject == 4);
        @(posedge clk); #1;
        check("post_done", done4, 0);
        check("post_ready", ready4, 1);
        check("post_busy", busy4, 0);
        check("hold_result", result4, exp_res);
        check("hold_cout", cout4, exp_c);
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk); #1;
        check("idle_no_extra_done", done4, 0);
        check("idle_ready", ready4, 1);
        check("idle_add_cin", add_cin4, 0);
    endtask

    // One WORDS = 1 operation: a single adder pass.
    task automatic run_op1(input logic [3:0] av, input logic [3:0] bv,
                           input logic cv, input logic sv);
        int full, exp_res;
        logic exp_c;
        if (sv) begin
            exp_res = (int'(av) - int'(bv)) & 15;
            exp_c   = (av >= bv);
        end else begin
            full    = int'(av) + int'(bv) + int'(cv);
            exp_res = full & 15;
            exp_c   = (full > 15);
        end
        @(negedge clk);
        a1 = av; b1 = bv; cin1 = cv; sub1 = sv; start1 = 1'b1;
        @(posedge clk); #1;
        check("w1_busy", busy1, 1);
        check("w1_add_cin", add_cin1, sv ? 1'b1 : cv);
        @(negedge clk);
        start1 = 1'b0;
        a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
        @(posedge clk); #1;
        check("w1_done", done1, 1);
        check("w1_result", result1, 64'(exp_res));
        check("w1_cout", cout1, exp_c);
        @(posedge clk); #1;
        check("w1_ready", ready1, 1);
    endtask

    initial begin
        // Reset with start held high: reset must win.
        start4 = 1'b1;
        start1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready4, 1);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_result", result4, 0);
        check("rst_cout", cout4, 0);
        check("rst_add_a", add_a4, 0);
        check("rst_add_b", add_b4, 0);
        check("rst_add_cin", add_cin4, 0);
        check("rst1_ready", ready1, 1);
        check("rst1_busy", busy1, 0);
        @(negedge clk);
        reset4 = 1'b0; reset1 = 1'b0; start4 = 1'b0; start1 = 1'b0;

        // Directed WORDS = 4 cases.
        run_op4(16'h1234, 16'h0FCD, 1'b0, 1'b0, -1);
        run_op4(16'hFFFF, 16'h0001, 1'b0, 1'b0, -1);
        run_op4(16'h1000, 16'h0001, 1'b1, 1'b1, -1);
        run_op4(16'h0000, 16'h0001, 1'b1, 1'b1, -1);
        // Stray start two cycles into a running operation, then during DONE.
        run_op4(16'h0005, 16'h0003, 1'b0, 1'b0, 2);
        run_op4(16'h0005, 16'h0003, 1'b0, 1'b0, 4);

        // Reset while RUN is on nibble 2.
        @(negedge clk);
        a4 = 16'h1234; b4 = 16'h1111; cin4 = 1'b1; sub4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset4 = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", ready4, 1);
        check("midrst_busy", busy4, 0);
        check("midrst_done", done4, 0);
        check("midrst_result", result4, 0);
        check("midrst_cout", cout4, 0);
        check("midrst_add_cin", add_cin4, 0);
        @(negedge clk);
        reset4 = 1'b0;
        run_op4(16'h00FF, 16'h0001, 1'b0, 1'b0, -1);

        // Random WORDS = 4 operations, some with a stray start pulse.
        for (int n = 0; n < 60; n++) begin
            run_op4(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 7)));
        end

        // Exhaustive WORDS = 1.
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++)
                        run_op1(4'(x), 4'(y), 1'(c), 1'(s));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
